// File: rtl/div_pkg.sv
// Shared definitions for the iterative radix-2 restoring divider.
// Holds the mul_div_op bit positions used by the divider, the FSM state type,
// the iteration count and the width of the iteration counter.
package div_pkg;

  // Positions of the divider ops inside the one-hot mul_div_op bus
  localparam int unsigned DIV_W  = 3;
  localparam int unsigned MOD_W  = 4;
  localparam int unsigned DIV_WU = 5;
  localparam int unsigned MOD_WU = 6;

  localparam int unsigned ITER  = 32;
  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration (purely combinational).
// Ports:
//   part_hi_i  upper 33 bits of the left-shifted partial remainder
//   divisor_i  divisor magnitude
//   rem_hi_o   new upper partial remainder (difference or restored value)
//   q_bit_o    quotient bit (1 when the trial subtraction is non-negative)
module div_step (
  input  logic [32:0] part_hi_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] rem_hi_o,
  output logic        q_bit_o
);

  logic [32:0] diff;

  // The partial remainder stays below twice the divisor, so bit 32 of the
  // difference is a reliable sign bit.
  assign diff     = part_hi_i - {1'b0, divisor_i};
  assign q_bit_o  = ~diff[32];
  assign rem_hi_o = q_bit_o ? diff[31:0] : part_hi_i[31:0];

endmodule

// File: rtl/div.sv
// Iterative radix-2 restoring integer divider for the EX stage.
// Executes div.w / mod.w / div.wu / mod.wu under a start/done handshake.
// Ports:
//   clk, resetn   clock, asynchronous active-low reset
//   mul_div_op    one-hot op bus, bits [6:3] select the divider ops
//   alu_src1/2    dividend / divisor, captured on an accepted start
//   div_start     start request (honoured in IDLE or DONE only)
//   div_cancel    flush; aborts an operation in flight, blocks a start
//   div_busy      high in CALC and FIX
//   div_done      one-cycle pulse in DONE
//   div_result    quotient or remainder, held until the next result
// Build option: DIV_FAST_PATH_EN skips the iteration when the divisor is zero
// or the dividend magnitude is below the divisor magnitude.
module div
#(
  parameter int unsigned DW   = 32,
  parameter int unsigned ITER = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [9:0]    mul_div_op,
  input  logic [DW-1:0] alu_src1,
  input  logic [DW-1:0] alu_src2,
  input  logic          div_start,
  input  logic          div_cancel,
  output logic          div_busy,
  output logic          div_done,
  output logic [DW-1:0] div_result
);

  import div_pkg::*;

  div_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*DW-1:0] rem_q, rem_d;      // {partial remainder, dividend/quotient}
  logic [DW-1:0]   divisor_q, divisor_d;
  logic            q_neg_q, q_neg_d;
  logic            r_neg_q, r_neg_d;
  logic            rem_sel_q, rem_sel_d;
  logic [DW-1:0]   result_q, result_d;

  logic          is_div_op;
  logic          is_signed;
  logic          s1, s2;
  logic [DW-1:0] mag1, mag2;
  logic          start_ok;
  logic [DW-1:0] quo_fix, rem_fix;
  logic [32:0]   step_hi;
  logic [31:0]   step_div;
  logic [31:0]   step_rem;
  logic          step_q;
  logic          unused_op_bits;

  assign unused_op_bits = ^{mul_div_op[9:7], mul_div_op[2:0]};

  assign is_div_op = |mul_div_op[MOD_WU:DIV_W];
  assign is_signed = mul_div_op[DIV_W] | mul_div_op[MOD_W];
  assign s1        = is_signed & alu_src1[DW-1];
  assign s2        = is_signed & alu_src2[DW-1];
  assign mag1      = s1 ? (~alu_src1 + 1'b1) : alu_src1;
  assign mag2      = s2 ? (~alu_src2 + 1'b1) : alu_src2;
  assign start_ok  = div_start & is_div_op & ~div_cancel;

`ifdef DIV_FAST_PATH_EN
  logic div_zero;
  logic fast;

  // Outside CALC the step unit doubles as the |dividend| < |divisor| compare.
  assign step_hi  = (state_q == CALC) ? rem_q[2*DW-1:DW-1] : {1'b0, mag1};
  assign step_div = (state_q == CALC) ? divisor_q : mag2;
  assign div_zero = (mag2 == '0);
  assign fast     = div_zero | ~step_q;
`else
  assign step_hi  = rem_q[2*DW-1:DW-1];
  assign step_div = divisor_q;
`endif

  div_step u_step (
    .part_hi_i (step_hi),
    .divisor_i (step_div),
    .rem_hi_o  (step_rem),
    .q_bit_o   (step_q)
  );

  assign quo_fix = q_neg_q ? (~rem_q[DW-1:0] + 1'b1) : rem_q[DW-1:0];
  assign rem_fix = r_neg_q ? (~rem_q[2*DW-1:DW] + 1'b1) : rem_q[2*DW-1:DW];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    divisor_d = divisor_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    rem_sel_d = rem_sel_q;
    result_d  = result_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) begin
          state_d = IDLE;
        end
        if (start_ok) begin
          rem_sel_d = mul_div_op[MOD_W] | mul_div_op[MOD_WU];
          q_neg_d   = s1 ^ s2;
          r_neg_d   = s1;
          divisor_d = mag2;
          cnt_d     = '0;
          rem_d     = {{DW{1'b0}}, mag1};
          state_d   = CALC;
`ifdef DIV_FAST_PATH_EN
          if (fast) begin
            // Same values the full iteration would leave behind.
            rem_d   = {mag1, {DW{div_zero}}};
            state_d = FIX;
          end
`endif
        end
      end
      CALC: begin
        if (div_cancel) begin
          state_d = IDLE;
        end else begin
          rem_d = {step_rem, rem_q[DW-2:0], step_q};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(ITER - 1)) begin
            state_d = FIX;
          end
        end
      end
      FIX: begin
        if (div_cancel) begin
          state_d = IDLE;
        end else begin
          result_d = rem_sel_q ? rem_fix : quo_fix;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      rem_sel_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      divisor_q <= divisor_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      rem_sel_q <= rem_sel_d;
      result_q  <= result_d;
    end
  end

  assign div_busy   = (state_q == CALC) || (state_q == FIX);
  assign div_done   = (state_q == DONE);
  assign div_result = result_q;

endmodule
